// File: rtl/uart_pkg.sv
// Shared UART framing constants and the mode decode used by the game link
// transmitter.
package uart_pkg;

  localparam logic [7:0]  SYNC_MASTER = 8'hA5;
  localparam logic [7:0]  SYNC_SLAVE  = 8'h5A;
  localparam int unsigned MASTER_LEN  = 8;
  localparam int unsigned SLAVE_LEN   = 4;

  // MODE_MASTER is the all-zero encoding, so a cleared snapshot reads as MASTER.
  typedef enum logic [1:0] {
    MODE_MASTER = 2'd0,
    MODE_SLAVE  = 2'd1,
    MODE_LOCAL  = 2'd2
  } mode_t;

  function automatic mode_t decode_mode(input logic [2:1] sel);
    mode_t m;
    if (sel[2])      m = MODE_SLAVE;
    else if (sel[1]) m = MODE_LOCAL;
    else             m = MODE_MASTER;
    return m;
  endfunction

endpackage

// File: rtl/game_state_tx.sv
// Per-frame game state packetiser: snapshots ball/paddle on frame_tick and
// streams a framed, XOR-checksummed packet into the UART TX FIFO.
module game_state_tx
  import uart_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic [2:1]  sw,
  input  logic [10:0] x_ball,
  input  logic [9:0]  y_ball,
  input  logic [9:0]  y_player,
  input  logic        tx_full,
  output logic        wr_uart,
  output logic [7:0]  w_data,
  output logic        busy
);

  // state | meaning
  // IDLE  | waiting for an accepted frame_tick
  // LOAD  | checksum computed from the snapshot, no write
  // SEND  | write current byte when FIFO has room
  // GAP   | write-free cycle, advance byte index or finish
  typedef enum logic [1:0] {IDLE, LOAD, SEND, GAP} state_t;

  localparam logic [2:0] MASTER_LAST = 3'(MASTER_LEN - 1);
  localparam logic [2:0] SLAVE_LAST  = 3'(SLAVE_LEN - 1);

  state_t      state, state_next;
  mode_t       mode;
  mode_t       snap_mode, snap_mode_next;
  logic [10:0] snap_x, snap_x_next;
  logic [9:0]  snap_yb, snap_yb_next;
  logic [9:0]  snap_yp, snap_yp_next;
  logic [7:0]  csum, csum_next, csum_calc;
  logic [2:0]  idx, idx_next, last_idx;
  logic [7:0]  pkt_byte, data_next;
  logic        wr_next, busy_next;

  assign mode     = decode_mode(sw);
  assign last_idx = (snap_mode == MODE_SLAVE) ? SLAVE_LAST : MASTER_LAST;

  always_comb begin
    csum_calc = {6'b0, snap_yp[9:8]} ^ snap_yp[7:0];
    if (snap_mode != MODE_SLAVE)
      csum_calc = csum_calc ^ {5'b0, snap_x[10:8]} ^ snap_x[7:0]
                            ^ {6'b0, snap_yb[9:8]} ^ snap_yb[7:0];
  end

  always_comb begin
    pkt_byte = 8'h00;
    if (snap_mode == MODE_SLAVE) begin
      case (idx)
        3'd0:    pkt_byte = SYNC_SLAVE;
        3'd1:    pkt_byte = {6'b0, snap_yp[9:8]};
        3'd2:    pkt_byte = snap_yp[7:0];
        3'd3:    pkt_byte = csum;
        default: pkt_byte = 8'h00;
      endcase
    end else begin
      case (idx)
        3'd0:    pkt_byte = SYNC_MASTER;
        3'd1:    pkt_byte = {5'b0, snap_x[10:8]};
        3'd2:    pkt_byte = snap_x[7:0];
        3'd3:    pkt_byte = {6'b0, snap_yb[9:8]};
        3'd4:    pkt_byte = snap_yb[7:0];
        3'd5:    pkt_byte = {6'b0, snap_yp[9:8]};
        3'd6:    pkt_byte = snap_yp[7:0];
        default: pkt_byte = csum;
      endcase
    end
  end

  always_comb begin
    state_next     = state;
    idx_next       = idx;
    snap_mode_next = snap_mode;
    snap_x_next    = snap_x;
    snap_yb_next   = snap_yb;
    snap_yp_next   = snap_yp;
    csum_next      = csum;
    wr_next        = 1'b0;
    data_next      = w_data;
    case (state)
      IDLE: begin
        if (frame_tick && mode != MODE_LOCAL) begin
          state_next     = LOAD;
          idx_next       = 3'd0;
          snap_mode_next = mode;
          snap_x_next    = x_ball;
          snap_yb_next   = y_ball;
          snap_yp_next   = y_player;
        end
      end
      LOAD: begin
        csum_next  = csum_calc;
        state_next = SEND;
      end
      SEND: begin
        // Backpressure simply parks here; the index is untouched.
        if (!tx_full) begin
          wr_next    = 1'b1;
          data_next  = pkt_byte;
          state_next = GAP;
        end
      end
      GAP: begin
        if (idx == last_idx) begin
          state_next = IDLE;
          idx_next   = 3'd0;
        end else begin
          idx_next   = idx + 3'd1;
          state_next = SEND;
        end
      end
      default: state_next = IDLE;
    endcase
    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= 3'd0;
      snap_mode <= MODE_MASTER;
      snap_x    <= '0;
      snap_yb   <= '0;
      snap_yp   <= '0;
      csum      <= 8'h00;
      wr_uart   <= 1'b0;
      w_data    <= 8'h00;
      busy      <= 1'b0;
    end else begin
      state     <= state_next;
      idx       <= idx_next;
      snap_mode <= snap_mode_next;
      snap_x    <= snap_x_next;
      snap_yb   <= snap_yb_next;
      snap_yp   <= snap_yp_next;
      csum      <= csum_next;
      wr_uart   <= wr_next;
      w_data    <= data_next;
      busy      <= busy_next;
    end
  end

endmodule

// File: tb/tb_game_state_tx.sv
// Directed bench for game_state_tx with a packet-level reference model and a
// per-cycle compare process.
module tb_game_state_tx;

  logic        clk = 1'b0;
  logic        rst, frame_tick, tx_full;
  logic [2:1]  sw;
  logic [10:0] x_ball;
  logic [9:0]  y_ball, y_player;
  logic        wr_uart, busy;
  logic [7:0]  w_data;

  game_state_tx dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .sw(sw),
    .x_ball(x_ball), .y_ball(y_ball), .y_player(y_player),
    .tx_full(tx_full), .wr_uart(wr_uart), .w_data(w_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Packet as a list of bytes; the checksum folds every byte after the header.
  function automatic logic [7:0] model_byte(input bit master, input int x, input int yb,
                                            input int yp, input int i);
    logic [7:0] b[8];
    int n;
    logic [7:0] c;
    for (int k = 0; k < 8; k++) b[k] = 8'h00;
    if (master) begin
      b[0] = 8'hA5;
      b[1] = 8'(x / 256);  b[2] = 8'(x % 256);
      b[3] = 8'(yb / 256); b[4] = 8'(yb % 256);
      b[5] = 8'(yp / 256); b[6] = 8'(yp % 256);
      n = 8;
    end else begin
      b[0] = 8'h5A;
      b[1] = 8'(yp / 256); b[2] = 8'(yp % 256);
      n = 4;
    end
    c = 8'h00;
    for (int k = 1; k < n - 1; k++) c = c ^ b[k];
    b[n-1] = c;
    return b[i];
  endfunction

  // Driver-owned request state.
  int  tick_req = 0, rst_req = 0, tick_edge = 0;
  bit  tick_master;
  int  tick_x, tick_yb, tick_yp;

  // Compare-process-owned model state.
  int         tick_seen = 0, rst_seen = 0;
  bit         model_busy = 1'b0, last_done = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         strobe_cyc_q[$];
  logic [7:0] last_written = 8'h00;
  int         last_strobe_cyc = -10;

  always @(negedge clk) begin
    if (rst_req != rst_seen) begin
      rst_seen     = rst_req;
      model_busy   = 1'b0;
      last_done    = 1'b0;
      exp_q.delete();
      last_written = 8'h00;
      tick_seen    = tick_req;
      chk("reset_wr_uart", int'(wr_uart), 0);
      chk("reset_w_data", int'(w_data), 0);
      chk("reset_busy", int'(busy), 0);
    end else begin
      if (last_done) begin
        model_busy = 1'b0;
        last_done  = 1'b0;
      end
      if (tick_req != tick_seen) begin
        tick_seen  = tick_req;
        model_busy = 1'b1;
        for (int i = 0; i < (tick_master ? 8 : 4); i++)
          exp_q.push_back(model_byte(tick_master, tick_x, tick_yb, tick_yp, i));
      end
      chk("busy", int'(busy), int'(model_busy));
      if (wr_uart) begin
        if (exp_q.size() == 0) begin
          chk("spurious_strobe_w_data", int'(w_data), -1);
        end else begin
          chk("packet_byte", int'(w_data), int'(exp_q.pop_front()));
          if (exp_q.size() == 0) last_done = 1'b1;
        end
        chk("strobe_while_tx_full", int'(tx_full), 0);
        chk("strobe_spacing_ge2", int'(cyc - last_strobe_cyc >= 2), 1);
        last_strobe_cyc = cyc;
        last_written    = w_data;
        got_q.push_back(w_data);
        strobe_cyc_q.push_back(cyc);
      end else begin
        chk("w_data_hold", int'(w_data), int'(last_written));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  // Called at negedge+1; tick is sampled on the following posedge.
  task automatic do_tick();
    frame_tick = 1'b1;
    if (!model_busy && sw != 2'b01 && !rst) begin
      tick_master = !sw[2];
      tick_x      = int'(x_ball);
      tick_yb     = int'(y_ball);
      tick_yp     = int'(y_player);
      tick_edge   = cyc + 1;
      tick_req++;
    end
    @(negedge clk); #1;
    frame_tick = 1'b0;
  endtask

  task automatic wait_bytes(input int n);
    int k = 0;
    while (got_q.size() < n && k < 300) begin @(negedge clk); #1; k++; end
    if (got_q.size() < n) chk("wait_bytes_timeout", got_q.size(), n);
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((model_busy || exp_q.size() != 0) && k < 300) begin @(negedge clk); #1; k++; end
    if (model_busy || exp_q.size() != 0) chk("wait_idle_timeout", exp_q.size(), 0);
    idle(2);
  endtask

  logic [7:0] m_lit[8];
  logic [7:0] s_lit[4];
  int base, sbase;

  initial begin
    m_lit[0] = 8'hA5; m_lit[1] = 8'h01; m_lit[2] = 8'h90; m_lit[3] = 8'h01;
    m_lit[4] = 8'h2C; m_lit[5] = 8'h00; m_lit[6] = 8'hFA; m_lit[7] = 8'h46;
    s_lit[0] = 8'h5A; s_lit[1] = 8'h01; s_lit[2] = 8'h80; s_lit[3] = 8'h81;

    rst = 1'b1; frame_tick = 1'b0; tx_full = 1'b0; sw = 2'b00;
    x_ball = '0; y_ball = '0; y_player = '0;
    rst_req = 1;
    @(negedge clk); #1;
    rst = 1'b0;
    idle(2);

    // Pin the reference model against hand-computed packets.
    for (int i = 0; i < 8; i++) chk("model_master", int'(model_byte(1'b1, 400, 300, 250, i)), int'(m_lit[i]));
    for (int i = 0; i < 4; i++) chk("model_slave", int'(model_byte(1'b0, 0, 0, 384, i)), int'(s_lit[i]));
    chk("model_master_max_csum", int'(model_byte(1'b1, 2047, 1023, 5, 7)), 8'h01);

    // MASTER packet, latency, spacing; a tick in the final GAP cycle is dropped.
    sw = 2'b00; x_ball = 11'd400; y_ball = 10'd300; y_player = 10'd250;
    base = got_q.size(); sbase = strobe_cyc_q.size();
    do_tick();
    wait_bytes(base + 8);
    do_tick();
    wait_idle();
    idle(6);
    chk("master_len", got_q.size() - base, 8);
    for (int i = 0; i < 8; i++) chk("master_lit", int'(got_q[base+i]), int'(m_lit[i]));
    if (strobe_cyc_q.size() >= sbase + 8) begin
      chk("first_strobe_latency", strobe_cyc_q[sbase] + 1 - tick_edge, 3);
      for (int i = 1; i < 8; i++) chk("strobe_period", strobe_cyc_q[sbase+i] - strobe_cyc_q[sbase+i-1], 2);
    end
    chk("master_busy_end", int'(busy), 0);

    // SLAVE packet.
    sw = 2'b10; y_player = 10'd384;
    base = got_q.size();
    do_tick();
    wait_idle();
    chk("slave_len", got_q.size() - base, 4);
    for (int i = 0; i < 4 && base + i < got_q.size(); i++) chk("slave_lit", int'(got_q[base+i]), int'(s_lit[i]));
    chk("slave_busy_end", int'(busy), 0);

    // LOCAL: ticks ignored.
    sw = 2'b01;
    base = got_q.size();
    repeat (10) begin do_tick(); idle(1); end
    idle(5);
    chk("local_no_strobes", got_q.size() - base, 0);
    chk("local_busy", int'(busy), 0);

    // Backpressure before the fourth byte.
    sw = 2'b00; x_ball = 11'd2047; y_ball = 10'd1023; y_player = 10'd5;
    base = got_q.size();
    do_tick();
    wait_bytes(base + 3);
    tx_full = 1'b1;
    idle(20);
    chk("bp_stalled", got_q.size() - base, 3);
    tx_full = 1'b0;
    wait_idle();
    chk("bp_len", got_q.size() - base, 8);
    if (got_q.size() >= base + 8) begin
      chk("bp_byte3", int'(got_q[base+3]), 8'h03);
      chk("bp_csum", int'(got_q[base+7]), 8'h01);
    end

    // Mid-packet input changes only affect the next packet.
    sw = 2'b00; x_ball = 11'd400; y_ball = 10'd300; y_player = 10'd250;
    base = got_q.size();
    do_tick();
    wait_bytes(base + 3);
    x_ball = 11'd0; sw = 2'b10;
    wait_idle();
    chk("mid_len", got_q.size() - base, 8);
    for (int i = 0; i < 8 && base + i < got_q.size(); i++) chk("mid_lit", int'(got_q[base+i]), int'(m_lit[i]));
    base = got_q.size();
    do_tick();
    wait_idle();
    chk("mid_next_len", got_q.size() - base, 4);
    if (got_q.size() >= base + 4) begin
      chk("mid_next_hdr", int'(got_q[base]), 8'h5A);
      chk("mid_next_csum", int'(got_q[base+3]), 8'hFA);
    end

    // Reset mid-packet aborts; reset also beats a coincident tick.
    sw = 2'b00;
    base = got_q.size();
    do_tick();
    wait_bytes(base + 4);
    rst = 1'b1; rst_req++;
    @(negedge clk); #1;
    rst = 1'b0;
    idle(12);
    chk("rst_abort_len", got_q.size() - base, 4);
    rst = 1'b1; frame_tick = 1'b1; rst_req++;
    @(negedge clk); #1;
    rst = 1'b0; frame_tick = 1'b0;
    idle(10);
    chk("rst_over_tick", got_q.size() - base, 4);
    base = got_q.size();
    do_tick();
    wait_idle();
    chk("post_rst_len", got_q.size() - base, 8);
    if (got_q.size() > base) chk("post_rst_hdr", int'(got_q[base]), 8'hA5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
